// File: rtl/branch_redirect_unit_pkg.sv
// rtl/branch_redirect_unit_pkg.sv - shared widths, record layout and FSM encoding for the redirect unit
package branch_redirect_unit_pkg;

  localparam int EXCEP_SEG      = 6;
  localparam int EXCEP_MEM      = 2;
  localparam int ALL_CHECKPOINT = 8;
  localparam int REPAIR_ACTION  = 2;
  localparam logic [REPAIR_ACTION-1:0] NEED_REPAIR = 2'b01;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } redir_state_e;

  typedef struct packed {
    logic [31:0]               erro_vaddr;
    logic [31:0]               corr_dest;
    logic                      corr_take;
    logic [ALL_CHECKPOINT-1:0] check_point;
    logic [REPAIR_ACTION-1:0]  repair_action;
  } upd_rec_t;

  localparam int UPD_REC_W = $bits(upd_rec_t);

  // Not-taken branches resume after the delay slot, hence +8.
  function automatic logic [31:0] redirect_target(input logic [31:0] erro_vaddr,
                                                  input logic [31:0] corr_dest,
                                                  input logic        corr_take);
    return corr_take ? corr_dest : erro_vaddr + 32'd8;
  endfunction

endpackage

// File: rtl/bru_upd_fifo.sv
// rtl/bru_upd_fifo.sv - predictor-update FIFO; drops pushes when full and no pop, flagging a one-cycle pulse
module bru_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             drop_q;
  logic             push_en;
  logic             pop_en;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign pop_en  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_en = push_i && (!full_o || pop_en);
  assign head_o  = mem_q[rd_ptr_q];
  assign drop_o  = drop_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q  <= cnt_d;
      drop_q <= push_i && !push_en;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// rtl/branch_redirect_unit.sv - mispredict redirect FSM plus predictor-update queue
// Define BRU_PERF_CNT_EN to add the saturating mispredict counter output.
module branch_redirect_unit
  import branch_redirect_unit_pkg::*;
#(
  parameter int UPD_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      SBA_flush_w_i,
  input  logic [31:0]               SBA_erroVAddr_w_i,
  input  logic [31:0]               SBA_corrDest_w_i,
  input  logic                      SBA_corrTake_w_i,
  input  logic [ALL_CHECKPOINT-1:0] SBA_checkPoint_w_i,
  input  logic [REPAIR_ACTION-1:0]  SBA_repairAction_w_i,
  input  logic                      CP0_excOccur_w_i,
  input  logic [EXCEP_SEG-1:0]      CP0_exceptSeg_w_i,
  input  logic                      IF_redirReady_w_i,
  output logic                      BRU_redirValid_w_o,
  output logic [31:0]               BRU_redirPC_w_o,
  input  logic                      BPU_updReady_w_i,
  output logic                      BRU_updValid_w_o,
  output logic [UPD_REC_W-1:0]      BRU_updData_w_o,
  output logic                      BRU_updDrop_w_o
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]               BRU_mispredCnt_w_o
`endif
);

  redir_state_e state_q;
  logic         redir_valid_q;
  logic [31:0]  redir_pc_q;
  logic         exc_flush;
  logic [31:0]  target;
  upd_rec_t     push_rec;
  logic         fifo_full;
  logic         fifo_empty;
  logic         unused_seg_bits;

  assign exc_flush       = CP0_excOccur_w_i && CP0_exceptSeg_w_i[EXCEP_MEM];
  assign unused_seg_bits = ^CP0_exceptSeg_w_i;
  assign target          = redirect_target(SBA_erroVAddr_w_i, SBA_corrDest_w_i, SBA_corrTake_w_i);

  // An exception squashes the redirect but the branch outcome is still valid training data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else if (exc_flush) begin
      state_q       <= ST_IDLE;
      redir_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (SBA_flush_w_i) begin
            state_q       <= ST_ISSUE;
            redir_valid_q <= 1'b1;
            redir_pc_q    <= target;
          end
        end
        ST_ISSUE: begin
          if (SBA_flush_w_i) begin
            redir_pc_q <= target;
          end else if (IF_redirReady_w_i) begin
            state_q       <= ST_IDLE;
            redir_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          redir_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign BRU_redirValid_w_o = redir_valid_q;
  assign BRU_redirPC_w_o    = redir_pc_q;

  assign push_rec.erro_vaddr    = SBA_erroVAddr_w_i;
  assign push_rec.corr_dest     = SBA_corrDest_w_i;
  assign push_rec.corr_take     = SBA_corrTake_w_i;
  assign push_rec.check_point   = SBA_checkPoint_w_i;
  assign push_rec.repair_action = SBA_repairAction_w_i;

  bru_upd_fifo #(
    .DEPTH (UPD_DEPTH),
    .WIDTH (UPD_REC_W)
  ) u_upd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (SBA_flush_w_i),
    .data_i  (push_rec),
    .pop_i   (BPU_updReady_w_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (BRU_updDrop_w_o),
    .head_o  (BRU_updData_w_o)
  );

  assign BRU_updValid_w_o = !fifo_empty;

  logic unused_full;
  assign unused_full = fifo_full;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] mispred_cnt_q;
  logic [31:0] mispred_cnt_d;

  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (SBA_flush_w_i && (mispred_cnt_q != 32'hFFFF_FFFF)) mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mispred_cnt_q <= '0;
    else      mispred_cnt_q <= mispred_cnt_d;
  end

  assign BRU_mispredCnt_w_o = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// tb/tb_branch_redirect_unit.sv - vector table, corner sequences and randomized run against a queue model
module tb_branch_redirect_unit;
  import branch_redirect_unit_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] erro = '0;
  logic [31:0] dest = '0;
  logic        take = 1'b0;
  logic [ALL_CHECKPOINT-1:0] cp = '0;
  logic [REPAIR_ACTION-1:0]  ra = '0;
  logic        exc = 1'b0;
  logic [EXCEP_SEG-1:0] seg = '0;
  logic        ifr = 1'b0;
  logic        bpur = 1'b0;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        upd_valid;
  logic [UPD_REC_W-1:0] upd_data;
  logic        upd_drop;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] mispred_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: pending redirect and a plain queue of training records.
  logic                 m_pend = 1'b0;
  logic [31:0]          m_pc = '0;
  logic [UPD_REC_W-1:0] m_q[$];
  logic                 m_drop = 1'b0;
  logic [31:0]          m_cnt = '0;

  branch_redirect_unit #(.UPD_DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .SBA_flush_w_i        (flush),
    .SBA_erroVAddr_w_i    (erro),
    .SBA_corrDest_w_i     (dest),
    .SBA_corrTake_w_i     (take),
    .SBA_checkPoint_w_i   (cp),
    .SBA_repairAction_w_i (ra),
    .CP0_excOccur_w_i     (exc),
    .CP0_exceptSeg_w_i    (seg),
    .IF_redirReady_w_i    (ifr),
    .BRU_redirValid_w_o   (redir_valid),
    .BRU_redirPC_w_o      (redir_pc),
    .BPU_updReady_w_i     (bpur),
    .BRU_updValid_w_o     (upd_valid),
    .BRU_updData_w_o      (upd_data),
    .BRU_updDrop_w_o      (upd_drop)
`ifdef BRU_PERF_CNT_EN
    ,
    .BRU_mispredCnt_w_o   (mispred_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [UPD_REC_W-1:0] make_rec();
    return {erro, dest, take, cp, ra};
  endfunction

  task automatic model_clear();
    m_pend = 1'b0;
    m_q.delete();
    m_drop = 1'b0;
    m_cnt = '0;
  endtask

  task automatic model_step();
    logic was_full;
    logic pop;
    was_full = (m_q.size() == DEPTH);
    pop = (m_q.size() != 0) && bpur;
    m_drop = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (flush) begin
      if (was_full && !pop) m_drop = 1'b1;
      else m_q.push_back(make_rec());
      if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
    end
    if (exc && seg[EXCEP_MEM]) m_pend = 1'b0;
    else if (flush) begin
      m_pend = 1'b1;
      m_pc = take ? dest : erro + 32'd8;
    end else if (m_pend && ifr) m_pend = 1'b0;
  endtask

  task automatic compare_model();
    chk("model_redir_valid", redir_valid, m_pend);
    if (m_pend) chk("model_redir_pc", redir_pc, m_pc);
    chk("model_upd_valid", upd_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("model_upd_data", upd_data, m_q[0]);
    chk("model_upd_drop", upd_drop, m_drop);
`ifdef BRU_PERF_CNT_EN
    chk("model_perf_cnt", mispred_cnt, m_cnt);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    flush = 1'b0; exc = 1'b0; seg = '0;
  endtask

  typedef struct {
    logic        flush;
    logic [31:0] erro;
    logic [31:0] dest;
    logic        take;
    logic        ifr;
    logic        exc;
    logic [5:0]  seg;
    logic        bpur;
    logic        ev;
    logic [31:0] epc;
    logic        eu;
  } vec_t;

  vec_t tbl[16];
  logic [UPD_REC_W-1:0] exp_rec[5];

  initial begin
    tbl[0]  = '{1'b1, 32'h8000_1000, 32'h8000_2000, 1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 32'h8000_2000, 1'b1};
    tbl[1]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0, 1'b1};
    tbl[2]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b1, 1'b0, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 32'h0000_0004, 1'b1};
    tbl[4]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 32'h0000_0004, 1'b0};
    tbl[5]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 32'h0000_0004, 1'b0};
    tbl[6]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 32'h0000_0004, 1'b0};
    tbl[7]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0, 1'b0};
    tbl[8]  = '{1'b1, 32'h0000_0100, 32'h0000_A000, 1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 32'h0000_A000, 1'b1};
    tbl[9]  = '{1'b1, 32'h0000_0200, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 32'h0000_0208, 1'b1};
    tbl[10] = '{1'b1, 32'h0000_0300, 32'h0000_C000, 1'b1, 1'b0, 1'b1, 6'h04, 1'b0, 1'b0, 32'h0, 1'b1};
    tbl[11] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b1, 1'b0, 32'h0, 1'b1};
    tbl[12] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b1, 1'b0, 32'h0, 1'b1};
    tbl[13] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b1, 1'b0, 32'h0, 1'b0};
    tbl[14] = '{1'b1, 32'h0000_0400, 32'h0000_D000, 1'b1, 1'b0, 1'b1, 6'h03, 1'b0, 1'b1, 32'h0000_D000, 1'b1};
    tbl[15] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b1, 1'b0, 32'h0, 1'b0};

    #2;
    chk("reset_redir_valid", redir_valid, 1'b0);
    chk("reset_redir_pc", redir_pc, 32'h0);
    chk("reset_upd_valid", upd_valid, 1'b0);
    chk("reset_upd_drop", upd_drop, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    model_clear();

    for (int i = 0; i < 16; i++) begin
      flush = tbl[i].flush; erro = tbl[i].erro; dest = tbl[i].dest; take = tbl[i].take;
      ifr = tbl[i].ifr; exc = tbl[i].exc; seg = tbl[i].seg; bpur = tbl[i].bpur;
      cp = 8'(i); ra = 2'(i);
      tick();
      chk($sformatf("tbl%0d_redir_valid", i), redir_valid, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("tbl%0d_redir_pc", i), redir_pc, tbl[i].epc);
      chk($sformatf("tbl%0d_upd_valid", i), upd_valid, tbl[i].eu);
    end
    idle_inputs();

    // Overflow: five pushes into four slots, then drain in push order.
    bpur = 1'b0; ifr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      flush = 1'b1; erro = 32'h1000 * (k + 1); dest = 32'h4000_0000 + k; take = k[0];
      cp = 8'(8'h30 + k); ra = 2'(k);
      exp_rec[k] = {erro, dest, take, cp, ra};
      tick();
    end
    chk("ovf_drop_pulse", upd_drop, 1'b1);
    flush = 1'b0;
    tick();
    chk("ovf_drop_clear", upd_drop, 1'b0);
    bpur = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf_pop%0d_valid", k), upd_valid, 1'b1);
      chk($sformatf("ovf_pop%0d_data", k), upd_data, exp_rec[k]);
      tick();
    end
    chk("ovf_drained", upd_valid, 1'b0);

    // Full with simultaneous push and pop keeps four entries and drops nothing.
    bpur = 1'b0;
    for (int k = 0; k < 4; k++) begin
      flush = 1'b1; erro = 32'h2000 + k; take = 1'b0; tick();
    end
    flush = 1'b1; erro = 32'h2100; bpur = 1'b1; tick();
    chk("full_pushpop_drop", upd_drop, 1'b0);
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("full_pushpop_cnt%0d", k), upd_valid, 1'b1);
      tick();
    end
    chk("full_pushpop_empty", upd_valid, 1'b0);

    // Asynchronous reset while issuing with two entries queued.
    bpur = 1'b0; ifr = 1'b0;
    flush = 1'b1; erro = 32'h5000; take = 1'b1; dest = 32'h6000; tick();
    erro = 32'h5100; tick();
    flush = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_redir_valid", redir_valid, 1'b0);
    chk("async_rst_redir_pc", redir_pc, 32'h0);
    chk("async_rst_upd_valid", upd_valid, 1'b0);
    chk("async_rst_upd_drop", upd_drop, 1'b0);
`ifdef BRU_PERF_CNT_EN
    chk("async_rst_perf_cnt", mispred_cnt, 32'h0);
`endif
    model_clear();
    @(posedge clk); #1;
    rst = 1'b1;
    ifr = 1'b1;
    tick();
    chk("post_rst_redir_valid", redir_valid, 1'b0);
    chk("post_rst_upd_valid", upd_valid, 1'b0);

`ifdef BRU_PERF_CNT_EN
    bpur = 1'b1;
    for (int k = 0; k < 7; k++) begin
      flush = 1'b1; erro = 32'h7000 + k;
      exc = (k == 3); seg = (k == 3) ? 6'h04 : 6'h00;
      tick();
    end
    idle_inputs();
    tick();
    chk("perf_cnt_seven", mispred_cnt, 32'd7);
`endif

    for (int n = 0; n < 400; n++) begin
      flush = ($urandom_range(0, 2) == 0);
      erro = $urandom; dest = $urandom; take = 1'($urandom_range(0, 1));
      cp = 8'($urandom); ra = 2'($urandom);
      exc = ($urandom_range(0, 9) == 0); seg = 6'($urandom);
      ifr = ($urandom_range(0, 2) != 0);
      bpur = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect_unit.md
BRANCH_REDIRECT_UNIT -- requirements
Module: branch_redirect_unit

Interface
REQ-001 SHALL have parameter UPD_DEPTH, default 4, BPU-update FIFO depth (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port SBA_flush_w_i, input, 1, branch mispredict detected this cycle.
REQ-005 SHALL have ports SBA_erroVAddr_w_i and SBA_corrDest_w_i, input, 32 each, mispredicted branch PC and correct target.
REQ-006 SHALL have port SBA_corrTake_w_i, input, 1, correct direction.
REQ-007 SHALL have ports SBA_checkPoint_w_i (ALL_CHECKPOINT width) and SBA_repairAction_w_i (REPAIR_ACTION width), input, predictor repair info.
REQ-008 SHALL have ports CP0_excOccur_w_i, input, 1, and CP0_exceptSeg_w_i, input, EXCEP_SEG width; exception flush when excOccur is high and the EXCEP_MEM bit is set.
REQ-009 SHALL have port IF_redirReady_w_i, input, 1, fetch accepts redirect.
REQ-010 SHALL have ports BRU_redirValid_w_o (1) and BRU_redirPC_w_o (32), output, fetch redirect request.
REQ-011 SHALL have ports BPU_updReady_w_i (input, 1), BRU_updValid_w_o (output, 1) and BRU_updData_w_o (output, {erroVAddr, corrDest, corrTake, checkPoint, repairAction}), predictor training stream.
REQ-012 SHALL have port BRU_updDrop_w_o, output, 1, one-cycle pulse when an update is dropped.

Function
REQ-013 SHALL compute target = corrTake ? corrDest : erroVAddr + 8 (delay-slot fall-through, 32-bit wrap).
REQ-014 SHALL implement redirect FSM with states IDLE and ISSUE.
REQ-015 IDLE: SBA_flush_w_i latches target, next state ISSUE; redirect visible exactly 1 cycle after flush.
REQ-016 ISSUE: BRU_redirValid_w_o=1; valid&&IF_redirReady_w_i -> IDLE; else hold target stable.
REQ-017 A new SBA_flush_w_i while in ISSUE SHALL overwrite the target and stay in ISSUE.
REQ-018 Exception flush SHALL force IDLE next cycle and override a simultaneous SBA_flush_w_i (no redirect latched).
REQ-019 Every SBA_flush_w_i SHALL push one entry into the update FIFO, exception flush included (training is retained).
REQ-020 FIFO pop on BRU_updValid_w_o&&BPU_updReady_w_i; BRU_updValid_w_o = not empty; head data driven combinationally from storage.
REQ-021 Full with push and pop the same cycle: both take effect, count unchanged.
REQ-022 Full with push and no pop: new entry dropped, BRU_updDrop_w_o pulses the following cycle, contents unchanged.
REQ-023 Pointers SHALL wrap modulo UPD_DEPTH; count width log2(UPD_DEPTH)+1.

Reset
REQ-024 rst low SHALL immediately force IDLE, empty FIFO, all outputs 0 (redirValid, redirPC, updValid, updDrop, perf counter).
REQ-025 Reset mid-ISSUE or with FIFO occupied SHALL discard the pending redirect and all entries; no output activity in the first cycle after release.

Configuration
REQ-026 Macro BRU_PERF_CNT_EN, defined: add output BRU_mispredCnt_w_o, 32, incrementing by 1 per accepted SBA_flush_w_i, saturating at 0xFFFFFFFF, unaffected by exception flush.
REQ-027 Macro BRU_PERF_CNT_EN undefined: port and counter absent; all other behaviour identical.

Structure
REQ-028 Shared package/defines file SHALL hold EXCEP_MEM index, ALL_CHECKPOINT, REPAIR_ACTION, NEED_REPAIR, the redirect FSM state encoding and the update-record width.
REQ-029 The FIFO SHALL be sub-module bru_upd_fifo (parameterised depth and width, push/pop/full/empty/drop); the FSM stays in the top.

Verification
REQ-030 Flush erroVAddr=0x80001000, corrTake=1, corrDest=0x80002000, ready=1 -> next cycle redirValid=1, redirPC=0x80002000 for 1 cycle; 1 FIFO entry.
REQ-031 Flush corrTake=0, erroVAddr=0xFFFFFFFC, ready=0 for 3 cycles -> redirPC=0x00000004 held 4 cycles, drops on the ready cycle.
REQ-032 Flush in ISSUE -> target replaced; then exception flush together with a third flush -> IDLE, no redirect, FIFO holds 3 entries.
REQ-033 updReady=0, 5 flushes with UPD_DEPTH=4 -> 4 entries, one updDrop pulse; then updReady=1 -> 4 pops in push order.
REQ-034 rst asserted mid-ISSUE with 2 entries queued -> outputs 0 asynchronously; after release FIFO empty.
REQ-035 BRU_PERF_CNT_EN defined, 7 flushes including one with a simultaneous exception -> BRU_mispredCnt_w_o=7.
